// File: rtl/riscv_mul.sv
// ---------------------------------------------------------------------------
// riscv_mul : iterative RV32M multiplier (MUL, MULH, MULHSU, MULHU)
//
// Radix-2 shift-add over operand magnitudes, followed by one sign-fix cycle
// that negates the 64-bit product when exactly one operand was negative and
// picks the low or high word.
//
// Ports
//   i_clk       clock, all state on posedge
//   i_rst_n     synchronous reset, active-low (priority over i_start)
//   i_start     latch operands and begin (aborts any operation in flight)
//   i_funct3    op select, [1:0]: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU; [2] unused
//   i_rs1_data  multiplicand
//   i_rs2_data  multiplier
//   o_result    selected word of the product, registered, qualify with finish
//   o_finish    result valid, held until next start or reset
//   o_busy      high while calculating or sign-fixing
//
// Build option
//   MUL_EARLY_EXIT_EN  when defined, the calculation loop also ends once the
//                      remaining multiplier bits are all zero (at least one
//                      step is always taken). Undefined: fixed 33-cycle
//                      latency and no early-exit comparator.
// ---------------------------------------------------------------------------
module riscv_mul #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [2:0]       i_funct3,
  input  logic [WIDTH-1:0] i_rs1_data,
  input  logic [WIDTH-1:0] i_rs2_data,
  output logic [WIDTH-1:0] o_result,
  output logic             o_finish,
  output logic             o_busy
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,
    OP_MULH   = 2'd1,
    OP_MULHSU = 2'd2,
    OP_MULHU  = 2'd3
  } op_t;

  state_t           r_state;
  state_t           w_next;

  op_t              r_op;
  logic             r_neg;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_finish;

  op_t              w_op;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [PW-1:0]    w_acc_step;
  logic [PW-1:0]    w_prod;
  logic             w_last_step;
  logic             w_unused_funct3;

  // Only the low two funct3 bits select the operation.
  assign w_unused_funct3 = i_funct3[2];

  // -------------------------------------------------------------------------
  // Operand preparation (used only on the start edge)
  // -------------------------------------------------------------------------
  assign w_op    = op_t'(i_funct3[1:0]);
  assign w_a_neg = i_rs1_data[WIDTH-1] & ((w_op == OP_MULH) || (w_op == OP_MULHSU));
  assign w_b_neg = i_rs2_data[WIDTH-1] & (w_op == OP_MULH);

  // Magnitude of the most negative value wraps to itself, which read as
  // unsigned is exactly the correct magnitude.
  assign w_a_mag = w_a_neg ? ('0 - i_rs1_data) : i_rs1_data;
  assign w_b_mag = w_b_neg ? ('0 - i_rs2_data) : i_rs2_data;

  // -------------------------------------------------------------------------
  // Shift-add step and sign fix
  // -------------------------------------------------------------------------
  assign w_acc_step = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_prod     = r_neg ? ('0 - r_acc) : r_acc;

`ifdef MUL_EARLY_EXIT_EN
  // The step being taken leaves nothing further to add once the shifted
  // multiplier is zero, so the loop may stop after it.
  assign w_last_step = (r_cnt == CW'(WIDTH - 1)) || ((r_mplier >> 1) == '0);
`else
  assign w_last_step = (r_cnt == CW'(WIDTH - 1));
`endif

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state and busy
  // -------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    o_busy = 1'b0;
    case (r_state)
      S_CALC: begin
        o_busy = 1'b1;
        if (w_last_step) begin
          w_next = S_FIX;
        end
      end
      S_FIX: begin
        o_busy = 1'b1;
        w_next = S_DONE;
      end
      default: begin
        w_next = r_state;
      end
    endcase
    // A start in any state restarts the operation from scratch.
    if (i_start) begin
      w_next = S_CALC;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_op     <= OP_MUL;
      r_neg    <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_finish <= 1'b0;
    end else if (i_start) begin
      r_op     <= w_op;
      r_neg    <= w_a_neg ^ w_b_neg;
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
      r_mplier <= w_b_mag;
      r_cnt    <= '0;
      r_finish <= 1'b0;
    end else begin
      case (r_state)
        S_CALC: begin
          r_acc    <= w_acc_step;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
        end
        S_FIX: begin
          r_result <= (r_op == OP_MUL) ? w_prod[WIDTH-1:0] : w_prod[PW-1:WIDTH];
          r_finish <= 1'b1;
        end
        default: begin
          r_finish <= r_finish;
        end
      endcase
    end
  end

  assign o_result = r_result;
  assign o_finish = r_finish;

endmodule
